// File: rtl/bram_burst_dp_if.sv
// Bus bundle for bram_burst_dp: byte-enabled write port, burst request
// handshake and the streamed read-beat channel.
interface bram_burst_dp_if #(
   parameter int DW = 32,
   parameter int AW = 10,
   parameter int LW = 8
);
   logic            wr_en;
   logic [DW/8-1:0] wr_be;
   logic [AW-1:0]   wr_addr;
   logic [DW-1:0]   wr_data;
   logic            rq_valid;
   logic            rq_ready;
   logic [AW-1:0]   rq_addr;
   logic [LW-1:0]   rq_len;
   logic            rd_valid;
   logic            rd_ready;
   logic [DW-1:0]   rd_data;
   logic            rd_last;
   logic            busy;

   modport master (
      output wr_en, wr_be, wr_addr, wr_data,
      output rq_valid, rq_addr, rq_len, rd_ready,
      input  rq_ready, rd_valid, rd_data, rd_last, busy
   );

   modport slave (
      input  wr_en, wr_be, wr_addr, wr_data,
      input  rq_valid, rq_addr, rq_len, rd_ready,
      output rq_ready, rd_valid, rd_data, rd_last, busy
   );
endinterface

// File: rtl/bram_burst_dp.sv
// Simple-dual-port block RAM: byte-enabled write port plus a burst read
// engine that streams beats through a 2-entry skid FIFO with back-pressure.
//
// state | meaning
// IDLE  | waiting for a burst request, rq_ready = 1
// ISSUE | issuing RAM reads, one per cycle while FIFO + in-flight has room
// DRAIN | all reads issued, waiting for the last beat to be accepted
module bram_burst_dp #(
   parameter int DW = 32,
   parameter int AW = 10,
   parameter int LW = 8
) (
   input  logic              CLK,
   input  logic              RST,
   bram_burst_dp_if.slave    bus
);
   localparam int DEPTH = 2**AW;
   localparam int BW    = DW/8;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [AW-1:0]    r_addr;
   logic [LW:0]      r_remaining;
   logic [LW-1:0]    r_beat;
   logic [LW-1:0]    r_len;
   logic [DW-1:0]    r_mem [DEPTH];
   logic [DW-1:0]    r_ram_q;
   logic             r_ram_vld;
   logic             r_ram_last;
   logic [DW-1:0]    r_fifo_data [2];
   logic [1:0]       r_fifo_last;
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_count;
   logic [2:0]       w_credit;
   logic             w_room;
   logic             w_issue;
   logic             w_accept;
   logic             w_pop;
   logic             w_rd_valid;
   logic             w_rq_ready;
   logic             w_busy;

   // A beat leaving the FIFO this cycle frees a slot, so it counts toward
   // room; otherwise a streaming burst would bubble every other cycle.
   assign w_credit   = {1'b0, r_count} + {2'b00, r_ram_vld} - {2'b00, w_pop};
   assign w_room     = (w_credit < 3'd2);
   assign w_rd_valid = (r_count != 2'd0);
   assign w_pop      = w_rd_valid & bus.rd_ready;
   assign w_accept   = w_rq_ready & bus.rq_valid;

   assign bus.rq_ready = w_rq_ready;
   assign bus.busy     = w_busy;
   assign bus.rd_valid = w_rd_valid;
   assign bus.rd_data  = w_rd_valid ? r_fifo_data[r_rd_ptr] : '0;
   assign bus.rd_last  = w_rd_valid & r_fifo_last[r_rd_ptr];

   // State register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state, issue strobe and status outputs.
   always_comb begin
      w_next     = r_state;
      w_rq_ready = 1'b0;
      w_busy     = 1'b0;
      w_issue    = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_rq_ready = 1'b1;
            if (bus.rq_valid) w_next = S_ISSUE;
         end
         S_ISSUE: begin
            w_busy = 1'b1;
            if (w_room) begin
               w_issue = 1'b1;
               if (r_remaining == {{LW{1'b0}}, 1'b1}) w_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            w_busy = 1'b1;
            if (w_pop && bus.rd_last) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Burst address, remaining-beat and beat-index counters.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_addr      <= '0;
         r_remaining <= '0;
         r_beat      <= '0;
         r_len       <= '0;
      end else if (w_accept) begin
         r_addr      <= bus.rq_addr;
         r_remaining <= {1'b0, bus.rq_len} + {{LW{1'b0}}, 1'b1};
         r_beat      <= '0;
         r_len       <= bus.rq_len;
      end else if (w_issue) begin
         r_addr      <= r_addr + {{(AW-1){1'b0}}, 1'b1};
         r_remaining <= r_remaining - {{LW{1'b0}}, 1'b1};
         r_beat      <= r_beat + {{(LW-1){1'b0}}, 1'b1};
      end
   end

   // RAM array: byte-enabled write and read-first synchronous read.
   always_ff @(posedge CLK) begin
      for (int i = 0; i < BW; i++) begin
         if (bus.wr_en && bus.wr_be[i]) r_mem[bus.wr_addr][8*i +: 8] <= bus.wr_data[8*i +: 8];
      end
      if (w_issue) r_ram_q <= r_mem[r_addr];
   end

   // In-flight read tag: valid and last-beat flag travel with the RAM output.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_ram_vld  <= 1'b0;
         r_ram_last <= 1'b0;
      end else begin
         r_ram_vld  <= w_issue;
         r_ram_last <= w_issue && (r_beat == r_len);
      end
   end

   // Two-entry output FIFO; head drives the read channel.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_fifo_data[0] <= '0;
         r_fifo_data[1] <= '0;
         r_fifo_last    <= '0;
         r_wr_ptr       <= 1'b0;
         r_rd_ptr       <= 1'b0;
         r_count        <= '0;
      end else begin
         if (r_ram_vld) begin
            r_fifo_data[r_wr_ptr] <= r_ram_q;
            r_fifo_last[r_wr_ptr] <= r_ram_last;
            r_wr_ptr              <= ~r_wr_ptr;
         end
         if (w_pop) r_rd_ptr <= ~r_rd_ptr;
         r_count <= r_count + {1'b0, r_ram_vld} - {1'b0, w_pop};
      end
   end
endmodule

// File: doc/bram_burst_dp.md
Name: bram_burst_dp

Overview:
- Parametrised simple-dual-port block RAM for the user project.
- Port A is a write port with byte enables.
- Port B is a burst read engine: it takes one start address and a beat count per request, then streams words over a valid/ready interface with full back-pressure support.
- Serves as the next-generation local buffer behind the Wishbone/AXI-stream glue, so one burst replaces per-word reads.

Parameters:
- DW, 32, data width in bits; must be a multiple of 8.
- AW, 10, address width in words; DEPTH = 2**AW.
- LW, 8, width of burst length field; max burst = 2**LW beats.

Ports:
- CLK  input  1  clock, all logic on rising edge.
- RST  input  1  asynchronous, active-high reset.
- wr_en  input  1  write strobe, port A.
- wr_be  input  DW/8  byte enables; bit i writes bits [8i+7:8i].
- wr_addr  input  AW  write word address.
- wr_data  input  DW  write data.
- rq_valid  input  1  burst request valid.
- rq_ready  output  1  engine can accept a request.
- rq_addr  input  AW  burst start word address.
- rq_len  input  LW  beats minus one (0 = 1 beat, 2**LW-1 = 2**LW beats).
- rd_valid  output  1  rd_data holds a valid beat.
- rd_ready  input  1  consumer accepts beat.
- rd_data  output  DW  read beat; forced to 0 when rd_valid = 0.
- rd_last  output  1  high with the final beat of a burst.
- busy  output  1  burst in progress (issue or drain).

Behaviour:
Reset:
- RST asserted is asynchronous: state = IDLE, rq_ready = 1, rd_valid = 0, rd_data = 0, rd_last = 0, busy = 0.
- All counters and the output buffer are cleared. RAM contents are not reset.
- RST mid-burst aborts the burst immediately and discards buffered beats. Writes in flight on that edge are not guaranteed.

Write port:
- On an edge with wr_en = 1, bytes selected by wr_be are written at wr_addr.
- wr_be = 0 writes nothing.
- Writes are independent of read state; they are never stalled.

Request handshake:
- A request is accepted on an edge where rq_valid & rq_ready.
- rq_ready = 1 only in IDLE. It is combinational from state, not from rq_valid.
- On acceptance, load addr <= rq_addr, remaining <= rq_len + 1 (LW+1 bits), beat counter <= 0.

State machine:
- IDLE -> ISSUE on acceptance.
- ISSUE: one RAM read is issued per cycle when (buffer occupancy + reads in flight) < 2.
  - Each issue increments addr modulo DEPTH (wraps 2**AW-1 -> 0) and decrements remaining.
  - remaining reaches 0 -> DRAIN.
- DRAIN -> IDLE on the edge where the last beat (rd_last) is accepted.
- busy = 1 in ISSUE and DRAIN.

Read datapath:
- RAM read is synchronous, 1-cycle latency, registered into a 2-entry output FIFO (skid).
- The head of the FIFO drives rd_data/rd_valid/rd_last.
- Latency: request accepted on edge E0, first read issued in cycle after E0, rd_valid high after edge E2.
- Throughput: with rd_ready held at 1, one beat per cycle, no bubbles.
- rd_ready low: rd_valid, rd_data and rd_last are held stable until accepted. Issue stalls once the FIFO plus in-flight reads reaches 2 entries; no beat is ever dropped or duplicated.
- rd_last is tagged on the beat whose index = rq_len.

Collision rule:
- A read issue and a write to the same address on the same edge return the old data (read-first).
- A write to an address not yet issued in the current burst is visible to the burst.

Boundary conditions:
- rq_len = 0: single beat, rd_last on the first beat.
- rq_len = 2**LW-1: the 2**LW-beat burst completes with a correct count and no counter overflow.
- rq_valid high while busy: ignored and not stored; the requester must hold it.
- A new request may be accepted on the edge right after the last beat is accepted (IDLE for one cycle minimum).

Test Plan:
1. Write 0x11223344 at addr 5 with wr_be=4'b1111, then 0xAA with wr_be=4'b0001. Burst addr 5, len 0 -> one beat 0x112233AA, rd_last=1, rd_valid first high 2 edges after acceptance.
2. Fill addr 0..15 with data = addr. Burst addr 0, len 15, rd_ready held 1 -> 16 consecutive beats 0..15 with no gaps, rd_last only on beat 15, busy drops after it.
3. Same burst with rd_ready toggling 1,0,0,1 pseudo-randomly -> beats 0..15 in order, no drops or duplicates, and rd_data is stable whenever rd_valid & !rd_ready.
4. AW=10, burst addr 1022, len 3 -> beats from addr 1022, 1023, 0, 1 (wrap-around).
5. During a burst from addr 8, write addr 8 on the same edge it is issued, and write addr 12 before it is issued -> beat 0 returns old data, beat 4 returns new data.
6. Assert RST for 1 cycle mid-burst at beat 3 of 10 -> rd_valid = 0, rd_data = 0, rq_ready = 1 asynchronously. A new burst afterwards returns correct pre-reset RAM contents.
